// File: rtl/icb_timer.sv
// icb_timer: ICB slave providing a prescaled 64-bit free-running counter,
// a 64-bit compare register and a level interrupt (PEND & IE).
`default_nettype none

module icb_timer #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int PRESC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            icb_cmd_vld,
  output logic            icb_cmd_rdy,
  input  logic [AW-1:0]   icb_cmd_addr,
  input  logic            icb_cmd_read,
  input  logic [DW-1:0]   icb_cmd_wdata,
  input  logic [DW/8-1:0] icb_cmd_wmask,
  output logic            icb_rsp_vld,
  input  logic            icb_rsp_rdy,
  output logic [DW-1:0]   icb_rsp_rdata,
  output logic            icb_rsp_err,
  output logic            interrupt_req
);

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_PRESC  = 5'h01;
  localparam logic [4:0] OFF_MTIME  = 5'h02;
  localparam logic [4:0] OFF_CMP    = 5'h03;
  localparam logic [4:0] OFF_STATUS = 5'h04;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [1:0]           r_ctrl;
  logic [PRESC_W-1:0]   r_presc;
  logic [PRESC_W-1:0]   r_psc_cnt;
  logic [DW-1:0]        r_mtime;
  logic [DW-1:0]        r_mtimecmp;
  logic                 r_pend;
  logic [DW-1:0]        r_rdata;
  logic                 r_err;

  logic [4:0]           w_off;
  logic                 w_sel_ctrl;
  logic                 w_sel_presc;
  logic                 w_sel_mtime;
  logic                 w_sel_cmp;
  logic                 w_sel_status;
  logic                 w_hit;
  logic                 w_acc;
  logic                 w_wr;
  logic                 w_clr;
  logic                 w_match;
  logic                 w_psc_wrap;
  logic                 w_tick;
  logic [DW-1:0]        w_bm;
  logic [DW-1:0]        w_rd_val;
  logic                 w_unused_addr;

  assign w_unused_addr = ^{icb_cmd_addr[AW-1:8], icb_cmd_addr[2:0]};

  assign w_off        = icb_cmd_addr[7:3];
  assign w_sel_ctrl   = (w_off == OFF_CTRL);
  assign w_sel_presc  = (w_off == OFF_PRESC);
  assign w_sel_mtime  = (w_off == OFF_MTIME);
  assign w_sel_cmp    = (w_off == OFF_CMP);
  assign w_sel_status = (w_off == OFF_STATUS);
  assign w_hit        = w_sel_ctrl | w_sel_presc | w_sel_mtime | w_sel_cmp | w_sel_status;

  assign w_acc   = icb_cmd_vld & icb_cmd_rdy;
  assign w_wr    = w_acc & ~icb_cmd_read;
  assign w_clr   = w_wr & w_sel_status & icb_cmd_wmask[0] & icb_cmd_wdata[0];
  assign w_match = (r_mtime >= r_mtimecmp);

  assign w_psc_wrap = (r_psc_cnt == r_presc);
  assign w_tick     = r_ctrl[0] & w_psc_wrap;

  always_comb begin
    w_bm = '0;
    for (int i = 0; i < DW/8; i++) begin
      w_bm[i*8 +: 8] = {8{icb_cmd_wmask[i]}};
    end
  end

  always_comb begin
    w_rd_val = '0;
    if (w_sel_ctrl)   w_rd_val = {{(DW-2){1'b0}}, r_ctrl};
    if (w_sel_presc)  w_rd_val = {{(DW-PRESC_W){1'b0}}, r_presc};
    if (w_sel_mtime)  w_rd_val = r_mtime;
    if (w_sel_cmp)    w_rd_val = r_mtimecmp;
    if (w_sel_status) w_rd_val = {{(DW-1){1'b0}}, r_pend};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    icb_cmd_rdy = 1'b0;
    icb_rsp_vld = 1'b0;
    case (r_state)
      S_IDLE: begin
        icb_cmd_rdy = 1'b1;
        if (icb_cmd_vld) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        icb_rsp_vld = 1'b1;
        if (icb_rsp_rdy) w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl     <= '0;
      r_presc    <= '0;
      r_psc_cnt  <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_pend     <= 1'b0;
    end else begin
      if (w_wr & w_sel_ctrl)
        r_ctrl <= (r_ctrl & ~w_bm[1:0]) | (icb_cmd_wdata[1:0] & w_bm[1:0]);
      if (w_wr & w_sel_presc)
        r_presc <= (r_presc & ~w_bm[PRESC_W-1:0]) | (icb_cmd_wdata[PRESC_W-1:0] & w_bm[PRESC_W-1:0]);
      if (w_wr & w_sel_cmp)
        r_mtimecmp <= (r_mtimecmp & ~w_bm) | (icb_cmd_wdata & w_bm);

      // Reprogramming the rate or enable restarts the prescale phase.
      if (w_wr & (w_sel_ctrl | w_sel_presc))
        r_psc_cnt <= '0;
      else if (r_ctrl[0])
        r_psc_cnt <= w_psc_wrap ? '0 : r_psc_cnt + PRESC_W'(1);

      if (w_wr & w_sel_mtime)
        r_mtime <= (r_mtime & ~w_bm) | (icb_cmd_wdata & w_bm);
      else if (w_tick)
        r_mtime <= r_mtime + DW'(1);

      r_pend <= w_match | (r_pend & ~w_clr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      r_rdata <= (icb_cmd_read & w_hit) ? w_rd_val : '0;
      r_err   <= ~w_hit;
    end
  end

  assign icb_rsp_rdata = r_rdata;
  assign icb_rsp_err   = r_err;
  assign interrupt_req = r_pend & r_ctrl[1];

endmodule

`default_nettype wire

// File: tb/tb_icb_timer.sv
// Bench for icb_timer: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a closed-form timer model.
`default_nettype none

module tb_icb_timer;

  logic        clk;
  logic        rst;
  logic        icb_cmd_vld;
  logic        icb_cmd_rdy;
  logic [63:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [63:0] icb_cmd_wdata;
  logic [7:0]  icb_cmd_wmask;
  logic        icb_rsp_vld;
  logic        icb_rsp_rdy;
  logic [63:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        interrupt_req;

  icb_timer #(.AW(64), .DW(64), .PRESC_W(16)) dut (
    .clk(clk), .rst(rst),
    .icb_cmd_vld(icb_cmd_vld), .icb_cmd_rdy(icb_cmd_rdy),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_vld(icb_rsp_vld), .icb_rsp_rdy(icb_rsp_rdy),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .interrupt_req(interrupt_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_true(input string name, input bit cond, input logic [63:0] act);
    n_chk++;
    if (!cond) begin
      n_err++;
      $display("FAIL %s: got %h outside allowed range", name, act);
    end
  endtask

  // Reference model: mtime is base value plus the number of prescaler
  // periods completed since the last phase anchor, counted after base_edge.
  int          cyc;
  bit          m_en, m_ie, m_pend, m_rp, m_err;
  int          m_presc;
  logic [63:0] m_cmp, m_bval, m_rdata;
  int          m_bedge, m_anc;

  function automatic logic [63:0] mt_at(input int e);
    int p;
    if (!m_en) return m_bval;
    p = m_presc + 1;
    return m_bval + 64'((e - m_anc) / p - (m_bedge - m_anc) / p);
  endfunction

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_pend = 0; m_rp = 0; m_err = 0;
    m_presc = 0; m_cmp = '1; m_bval = '0; m_rdata = '0;
    m_bedge = cyc; m_anc = cyc;
  endtask

  task automatic model_step();
    logic [63:0] old_mt, bm, rv, mv;
    logic [7:0]  off;
    bit          match, acc, wr, hit, clr, npend;
    cyc++;
    if (!rst) return;
    old_mt = mt_at(cyc - 1);
    match  = (old_mt >= m_cmp);
    acc    = icb_cmd_vld && !m_rp;
    wr     = acc && !icb_cmd_read;
    off    = {icb_cmd_addr[7:3], 3'b000};
    for (int b = 0; b < 8; b++) bm[b*8 +: 8] = {8{icb_cmd_wmask[b]}};
    hit    = (off <= 8'h20);
    clr    = wr && (off == 8'h20) && icb_cmd_wmask[0] && icb_cmd_wdata[0];
    npend  = match || (m_pend && !clr);
    if (m_rp && icb_rsp_rdy) m_rp = 0;
    if (acc) begin
      case (off)
        8'h00:   rv = {62'd0, m_ie, m_en};
        8'h08:   rv = 64'(m_presc);
        8'h10:   rv = old_mt;
        8'h18:   rv = m_cmp;
        8'h20:   rv = {63'd0, m_pend};
        default: rv = '0;
      endcase
      m_rp    = 1;
      m_err   = !hit;
      m_rdata = (icb_cmd_read && hit) ? rv : 64'd0;
      mv      = (rv & ~bm) | (icb_cmd_wdata & bm);
      if (wr) begin
        case (off)
          8'h00, 8'h08: begin
            m_bval  = mt_at(cyc);
            m_bedge = cyc;
            m_anc   = cyc;
            if (off == 8'h00) begin
              m_en = mv[0];
              m_ie = mv[1];
            end else begin
              m_presc = int'(mv[15:0]);
            end
          end
          8'h10: begin
            m_bval  = mv;
            m_bedge = cyc;
          end
          8'h18:   m_cmp = mv;
          default: ;
        endcase
      end
    end
    m_pend = npend;
  endtask

  task automatic check_outputs();
    chk("cmd_rdy", icb_cmd_rdy, 64'(!m_rp));
    chk("rsp_vld", icb_rsp_vld, 64'(m_rp));
    if (m_rp) begin
      chk("rsp_rdata", icb_rsp_rdata, m_rdata);
      chk("rsp_err", icb_rsp_err, 64'(m_err));
    end
    chk("interrupt_req", interrupt_req, 64'(m_pend && m_ie));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic xact(input bit rd, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] mask, input int stall,
                      output logic [63:0] rdata, output bit err, output int acc_e);
    int n;
    icb_cmd_vld   = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = addr;
    icb_cmd_wdata = wdata;
    icb_cmd_wmask = mask;
    icb_rsp_rdy   = 1'b0;
    n = 0;
    while (icb_cmd_rdy !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("cmd_rdy_timeout", 64'(icb_cmd_rdy), 64'd1);
    tick();
    acc_e = cyc;
    icb_cmd_vld = 1'b0;
    for (int i = 0; i < stall; i++) tick();
    rdata = icb_rsp_rdata;
    err   = icb_rsp_err;
    icb_rsp_rdy = 1'b1;
    tick();
    icb_rsp_rdy = 1'b0;
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] rd_d;
    bit          e;
    int          a;
    xact(1'b0, addr, d, m, 0, rd_d, e, a);
  endtask

  typedef struct {
    bit          rd;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic [63:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t        tbl[19];
  logic [63:0] rdata, first, v1, v2, d;
  logic [7:0]  offs[8];
  logic [7:0]  m;
  bit          err, rdb;
  int          acc_a, acc_r, n, k;

  initial begin
    tbl[0]  = '{1, 64'h00,  64'h0, 8'h00, 64'h0, 0};
    tbl[1]  = '{1, 64'h08,  64'h0, 8'h00, 64'h0, 0};
    tbl[2]  = '{1, 64'h10,  64'h0, 8'h00, 64'h0, 0};
    tbl[3]  = '{1, 64'h18,  64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    tbl[4]  = '{1, 64'h20,  64'h0, 8'h00, 64'h0, 0};
    tbl[5]  = '{0, 64'h18,  64'hAAAA_AAAA_AAAA_AAAA, 8'h01, 64'h0, 0};
    tbl[6]  = '{1, 64'h18,  64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFAA, 0};
    tbl[7]  = '{0, 64'h28,  64'h1234, 8'hFF, 64'h0, 1};
    tbl[8]  = '{1, 64'h28,  64'h0, 8'h00, 64'h0, 1};
    tbl[9]  = '{0, 64'h08,  64'h1234_5678, 8'hFF, 64'h0, 0};
    tbl[10] = '{1, 64'h0C,  64'h0, 8'h00, 64'h5678, 0};
    tbl[11] = '{0, 64'h10,  64'h1122_3344_5566_7788, 8'hF0, 64'h0, 0};
    tbl[12] = '{1, 64'h10,  64'h0, 8'h00, 64'h1122_3344_0000_0000, 0};
    tbl[13] = '{0, 64'h00,  64'hFE, 8'h01, 64'h0, 0};
    tbl[14] = '{1, 64'h07,  64'h0, 8'h00, 64'h2, 0};
    tbl[15] = '{0, 64'h00,  64'h0, 8'h00, 64'h0, 0};
    tbl[16] = '{1, 64'h00,  64'h0, 8'h00, 64'h2, 0};
    tbl[17] = '{0, 64'h00,  64'h0, 8'h01, 64'h0, 0};
    tbl[18] = '{1, 64'h118, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFAA, 0};
    offs = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'hF8};

    cyc = 0;
    rst = 1'b0;
    icb_cmd_vld = 1'b0; icb_cmd_read = 1'b0; icb_cmd_addr = '0;
    icb_cmd_wdata = '0; icb_cmd_wmask = '0; icb_rsp_rdy = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 19; i++) begin
      xact(tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].mask, 0, rdata, err, acc_a);
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
    end

    // Prescaled counting, then hold with EN=0.
    wr(64'h10, 64'h0, 8'hFF);
    wr(64'h08, 64'h3, 8'hFF);
    wr(64'h00, 64'h1, 8'h01);
    repeat (40) tick();
    xact(1'b1, 64'h10, 64'h0, 8'h00, 0, rdata, err, acc_r);
    chk_true("presc_mtime_10", rdata >= 64'd9 && rdata <= 64'd11, rdata);
    wr(64'h00, 64'h0, 8'h01);
    xact(1'b1, 64'h10, 64'h0, 8'h00, 0, v1, err, acc_r);
    repeat (20) tick();
    xact(1'b1, 64'h10, 64'h0, 8'h00, 0, v2, err, acc_r);
    chk("hold_mtime", v2, v1);

    // Wrap through 2^64 with PRESC=0.
    wr(64'h08, 64'h0, 8'hFF);
    wr(64'h10, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    xact(1'b0, 64'h00, 64'h1, 8'h01, 0, rdata, err, acc_a);
    tick();
    tick();
    xact(1'b1, 64'h10, 64'h0, 8'h00, 0, rdata, err, acc_r);
    chk("wrap_mtime", rdata, 64'hFFFF_FFFF_FFFF_FFFE + 64'(acc_r - 1 - acc_a));
    chk("wrap_mtime_is_1", rdata, 64'd1);
    wr(64'h00, 64'h0, 8'h01);

    // Interrupt on compare, W1C while matching, clear after moving compare.
    wr(64'h10, 64'h0, 8'hFF);
    wr(64'h18, 64'd50, 8'hFF);
    wr(64'h20, 64'h1, 8'h01);
    chk("irq_idle", 64'(interrupt_req), 64'd0);
    wr(64'h00, 64'h3, 8'h01);
    n = 0;
    while (!interrupt_req && n < 200) begin
      tick();
      n++;
    end
    chk("irq_rise_timeout", 64'(interrupt_req), 64'd1);
    xact(1'b1, 64'h10, 64'h0, 8'h00, 0, rdata, err, acc_r);
    chk_true("irq_mtime_ge_50", rdata >= 64'd50 && rdata <= 64'd60, rdata);
    wr(64'h20, 64'h1, 8'h01);
    xact(1'b1, 64'h20, 64'h0, 8'h00, 0, rdata, err, acc_r);
    chk("w1c_while_match", rdata, 64'd1);
    wr(64'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr(64'h20, 64'h1, 8'h01);
    chk("irq_cleared", 64'(interrupt_req), 64'd0);

    // Response backpressure.
    icb_cmd_vld = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 64'h18; icb_rsp_rdy = 1'b0;
    tick();
    icb_cmd_vld = 1'b0;
    first = icb_rsp_rdata;
    chk("bp_rdata", first, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 64'(icb_rsp_vld), 64'd1);
      chk("bp_cmd_rdy", 64'(icb_cmd_rdy), 64'd0);
      chk("bp_stable", icb_rsp_rdata, first);
      tick();
    end
    icb_rsp_rdy = 1'b1;
    tick();
    icb_rsp_rdy = 1'b0;
    chk("bp_release_rdy", 64'(icb_cmd_rdy), 64'd1);

    // Asynchronous reset in the middle of a pending response.
    wr(64'h00, 64'h3, 8'h01);
    icb_cmd_vld = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 64'h10;
    tick();
    icb_cmd_vld = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_rsp_vld", 64'(icb_rsp_vld), 64'd0);
    chk("rst_rdata", icb_rsp_rdata, 64'd0);
    chk("rst_irq", 64'(interrupt_req), 64'd0);
    model_reset();
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      xact(1'b1, tbl[i].addr, 64'h0, 8'h00, 0, rdata, err, acc_r);
      chk($sformatf("post_rst%0d_rdata", i), rdata, tbl[i].exp_rdata);
      chk($sformatf("post_rst%0d_err", i), 64'(err), 64'd0);
    end

    // Randomized traffic against the model.
    for (int t = 0; t < 400; t++) begin
      k   = $urandom_range(0, 7);
      rdb = 1'($urandom_range(0, 1));
      d   = {$urandom, $urandom};
      case (k)
        0: d = 64'($urandom_range(0, 3));
        1: d = 64'($urandom_range(0, 4));
        2: if ($urandom_range(0, 2) == 0) d = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
           else if ($urandom_range(0, 1) == 0) d = 64'($urandom_range(0, 100));
        3: if ($urandom_range(0, 1) == 0) d = mt_at(cyc) + 64'($urandom_range(0, 60));
        default: ;
      endcase
      m = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      v1 = {$urandom, $urandom};
      v1[7:0] = {offs[k][7:3], v1[2:0]};
      repeat ($urandom_range(0, 2)) tick();
      xact(rdb, v1, d, m, $urandom_range(0, 3), rdata, err, acc_r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icb_timer.md
# icb_timer

Memory-mapped 64-bit system timer on the peripheral (PPI) bus. An ICB slave sitting directly downstream of the PPI bridge's timer port, in the timer's address window. It provides a prescaled free-running 64-bit counter, a 64-bit compare register and a level interrupt toward the core's interrupt logic. It is the synthesizable timer for the non-simulation platform build.

## Interface
Parameters:
- AW, 64 — ICB address width; only addr[7:0] is decoded.
- DW, 64 — ICB data width; fixed at 64, wmask is DW/8 = 8 bits.
- PRESC_W, 16 — prescaler register and counter width.

Ports:
- clk  in  1  — single clock.
- rst  in  1  — asynchronous, active-low reset.
- icb_cmd_vld  in  1  — command valid.
- icb_cmd_rdy  out  1  — command ready.
- icb_cmd_addr  in  AW  — byte address.
- icb_cmd_read  in  1  — 1 = read, 0 = write.
- icb_cmd_wdata  in  DW  — write data.
- icb_cmd_wmask  in  DW/8  — byte-lane write enables.
- icb_rsp_vld  out  1  — response valid.
- icb_rsp_rdy  in  1  — response ready.
- icb_rsp_rdata  out  DW  — read data; 0 for writes and errors.
- icb_rsp_err  out  1  — unmapped-offset error.
- interrupt_req  out  1  — level timer interrupt.

## Operation
Register map, decoded on addr[7:0]; addr[2:0] is ignored:
- 0x00 CTRL: bit0 EN (count enable), bit1 IE (interrupt enable). Other bits read 0.
- 0x08 PRESC: [PRESC_W-1:0]. mtime advances once every PRESC+1 clk cycles.
- 0x10 MTIME: 64-bit counter.
- 0x18 MTIMECMP: 64-bit compare value.
- 0x20 STATUS: bit0 PEND. Read returns PEND. Writing 1 to bit0 (wmask[0] set) clears PEND; writing 0 has no effect.
- Any other offset: the write is discarded; icb_rsp_err=1, rdata=0.

Writes apply per byte lane under wmask. A lane with wmask=0 keeps its old value.

Counting:
- When EN=1: psc_cnt increments each cycle. When psc_cnt==PRESC, psc_cnt←0 and mtime←mtime+1, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFF wraps to 0).
- When EN=0: psc_cnt and mtime hold.
- A write to PRESC or CTRL resets psc_cnt to 0.
- An ICB write to MTIME in the same cycle as an increment: the write wins and the increment is lost for that cycle.

Interrupt:
- Match = (mtime >= mtimecmp), an unsigned 64-bit comparison on the current registered values.
- PEND is set on any cycle where Match=1, regardless of EN.
- When a W1C clear and Match=1 occur in the same cycle, the set wins.
- interrupt_req = PEND & IE, driven from registers with no combinational path from ICB inputs.

ICB protocol, at most one outstanding transaction:
- icb_cmd_rdy = ~rsp_pending.
- A command is accepted when vld & rdy. Accepting it sets rsp_pending, loads the response registers and performs any register write in that edge.
- Read data is the register value before any same-cycle update.
- icb_rsp_vld = rsp_pending. It stays high with stable rdata/err until icb_rsp_rdy=1, which clears rsp_pending.

State: IDLE (rsp_pending=0) → RESP on cmd accept → IDLE on rsp_rdy. There is no back-to-back accept in the cycle a response retires; the next accept is possible one cycle later.

## Timing
- Reset (rst=0, asynchronous):
  - CTRL=0, PRESC=0, psc_cnt=0, MTIME=0, MTIMECMP=0xFFFF_FFFF_FFFF_FFFF, PEND=0.
  - rsp_pending=0, so icb_cmd_rdy=1 once rst deasserts.
  - icb_rsp_vld=0, icb_rsp_rdata=0, icb_rsp_err=0, interrupt_req=0.
- Reset asserted mid-transaction drops the pending response immediately, with no response delivered.
- Command-to-response latency: 1 cycle (rsp_vld high in the cycle after accept). Throughput: one transaction per 2 cycles at best.
- A register write at accept edge N is visible to the counter/comparator from cycle N+1.
- PEND rises 1 cycle after Match becomes true; interrupt_req follows in the same cycle as PEND.
- With PRESC=0 and EN=1, mtime increments every cycle.

## Test plan
- Reset values: after reset, read all five registers → 0, 0, 0, 0xFFFF_FFFF_FFFF_FFFF, 0; interrupt_req=0; err=0 on each.
- Prescaled count: PRESC=3, CTRL=1, wait 40 cycles, read MTIME → 10 (±1 for read-edge alignment). CTRL=0, then two reads 20 cycles apart return equal values.
- Interrupt: MTIMECMP=50, PRESC=0, CTRL=3 → interrupt_req rises when mtime reaches 50. W1C STATUS → PEND stays 1 (Match still true). Set MTIMECMP=0xFFFF_FFFF_FFFF_FFFF, then W1C → interrupt_req=0 on the next cycle.
- Byte masks/wrap: write MTIME=0xFFFF_FFFF_FFFF_FFFE with all lanes, CTRL=1 → after 3 increments MTIME=1. Write wdata=0xAA.., wmask=0x01 to MTIMECMP → MTIMECMP=0xFFFF_FFFF_FFFF_FFAA.
- Handshake backpressure: hold icb_rsp_rdy=0 for 5 cycles after a read → rsp_vld stays 1, rdata stable, cmd_rdy=0. Release → cmd_rdy=1 the next cycle.
- Error/reset: write to 0x28 → err=1, no register change. Assert rst while rsp_vld=1 → rsp_vld=0 immediately and all registers return to reset values.
